// File: rtl/timer_bank.sv
// Multi-channel programmable down-counter timer bank with register port and level irq.
// Latency: register writes take effect next clk, reads return data 1 clk after re.
// Backpressure: none; the register port accepts one access per clk, always ready.
module timer_bank #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 16,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [NUM_CH-1:0] irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [ADDR_W-1:0] PEND_ADDR = ADDR_W'(2 * NUM_CH);
    localparam logic [ADDR_W-1:0] MASK_ADDR = ADDR_W'(2 * NUM_CH + 1);

    typedef struct packed {
        logic mode;
        logic en;
    } ctrl_t;

    logic [PW-1:0]     pre;
    logic              tick;
    logic [CNT_W-1:0]  period [NUM_CH];
    logic [CNT_W-1:0]  cnt    [NUM_CH];
    ctrl_t             ctrl   [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] mask;

    logic [NUM_CH-1:0] per_wr;
    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] w1c;
    logic              mask_wr;
    logic [DATA_W-1:0] rd_mux;

    assign tick = (pre == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    // A channel fires only when it is not being (re)started in the same cycle.
    always_comb begin
        per_wr  = '0;
        ctrl_wr = '0;
        start   = '0;
        fire    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            per_wr[i]  = we && (addr == ADDR_W'(2 * i));
            ctrl_wr[i] = we && (addr == ADDR_W'(2 * i + 1));
            start[i]   = ctrl_wr[i] && wdata[0] && !ctrl[i].en;
            fire[i]    = !start[i] && ctrl[i].en && tick && (cnt[i] == '0);
        end
    end

    assign w1c     = (we && addr == PEND_ADDR) ? wdata[NUM_CH-1:0] : '0;
    assign mask_wr = we && (addr == MASK_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
                ctrl[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (per_wr[i]) begin
                    period[i] <= wdata[CNT_W-1:0];
                end
                // Reloads use the period held before this cycle's write.
                if (start[i]) begin
                    cnt[i] <= period[i];
                end else if (fire[i]) begin
                    if (!ctrl[i].mode) begin
                        cnt[i] <= period[i];
                    end
                end else if (ctrl[i].en && tick) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
                if (ctrl_wr[i]) begin
                    ctrl[i] <= ctrl_t'(wdata[1:0]);
                end else if (fire[i] && ctrl[i].mode) begin
                    ctrl[i].en <= 1'b0;
                end
            end
        end
    end

    // A fresh event wins over a same-cycle clear of the same bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            mask <= '0;
        end else begin
            pend <= (pend & ~w1c) | fire;
            if (mask_wr) begin
                mask <= wdata[NUM_CH-1:0];
            end
        end
    end

    assign irq = pend & mask;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_W'(2 * i)) begin
                rd_mux[CNT_W-1:0] = period[i];
            end
            if (addr == ADDR_W'(2 * i + 1)) begin
                rd_mux[1:0] = ctrl[i];
            end
        end
        if (addr == PEND_ADDR) begin
            rd_mux[NUM_CH-1:0] = pend;
        end
        if (addr == MASK_ADDR) begin
            rd_mux[NUM_CH-1:0] = mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_mux;
        end
    end

endmodule
